// File: rtl/gpr_pkg.sv
// gpr_pkg: shared widths and writeback queue entry type for the GPR writeback path.
package gpr_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular writeback queue; exposes every slot in age order (oldest first) for bypass.
module wb_fifo
    import gpr_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  wb_entry_t             din,
    output wb_entry_t             dout,
    output logic                  full,
    output logic                  empty,
    output wb_entry_t [DEPTH-1:0] ents,
    output logic [DEPTH-1:0]      vld
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [AW:0]           count_q, count_d;
    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic                  do_push, do_pop;

    always_comb begin
        full    = count_q == (AW+1)'(DEPTH);
        empty   = count_q == '0;
        do_push = push && !full;
        do_pop  = pop && !empty;
        head_d  = head_q + AW'(do_pop);
        tail_d  = tail_q + AW'(do_push);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        mem_d   = mem_q;
        mem_d[tail_q] = do_push ? din : mem_q[tail_q];
        dout    = mem_q[head_q];
        // Slot k of the view is the k-th oldest entry; pointer sum wraps modulo DEPTH.
        for (int k = 0; k < DEPTH; k++) begin
            ents[k] = mem_q[head_q + AW'(k)];
            vld[k]  = (AW+1)'(k) < count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/gpr_wb_ctrl.sv
// gpr_wb_ctrl: queues register writebacks, drains them in order, and bypasses queued data to operands.
module gpr_wb_ctrl
    import gpr_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  gpr_wr_en,
    output logic                  gpr_we,
    output logic [REG_ADDR_W-1:0] gpr_rd,
    output logic [XLEN-1:0]       gpr_di,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [XLEN-1:0]       gpr_qa,
    input  logic [XLEN-1:0]       gpr_qb,
    output logic [XLEN-1:0]       op_a,
    output logic [XLEN-1:0]       op_b,
    output logic                  pending
);

    logic                  rst_dly_q, rst_dly_d;
    logic                  push, full, empty;
    wb_entry_t             din, head;
    wb_entry_t [DEPTH-1:0] ents;
    logic [DEPTH-1:0]      vld;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (gpr_we),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .ents  (ents),
        .vld   (vld)
    );

    always_comb begin
        rst_dly_d = rst;
        wb_ready  = !full && !rst && !rst_dly_q;
        push      = wb_valid && wb_ready && (wb_rd != '0);
        din       = '{rd: wb_rd, data: wb_data};
        gpr_we    = !empty && gpr_wr_en && !rst;
        gpr_rd    = head.rd;
        gpr_di    = head.data;
        pending   = !empty && !rst;
        op_a      = gpr_qa;
        op_b      = gpr_qb;
        // Walk oldest to youngest so the last match (youngest) wins.
        for (int k = 0; k < DEPTH; k++) begin
            op_a = (!rst && vld[k] && ents[k].rd == rs1) ? ents[k].data : op_a;
            op_b = (!rst && vld[k] && ents[k].rd == rs2) ? ents[k].data : op_b;
        end
        op_a = (rs1 == '0) ? '0 : op_a;
        op_b = (rs2 == '0) ? '0 : op_b;
    end

    always_ff @(posedge clk) begin
        rst_dly_q <= rst_dly_d;
    end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// tb_gpr_wb_ctrl: directed and random stimulus checked against a queue-based reference model.
module tb_gpr_wb_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, wb_valid, wb_ready, gpr_wr_en, gpr_we, pending;
    logic [4:0]  wb_rd, gpr_rd, rs1, rs2;
    logic [31:0] wb_data, gpr_di, gpr_qa, gpr_qb, op_a, op_b;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    bit   rst_prev = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gpr_wb_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .gpr_wr_en (gpr_wr_en),
        .gpr_we    (gpr_we),
        .gpr_rd    (gpr_rd),
        .gpr_di    (gpr_di),
        .rs1       (rs1),
        .rs2       (rs2),
        .gpr_qa    (gpr_qa),
        .gpr_qb    (gpr_qb),
        .op_a      (op_a),
        .op_b      (op_b),
        .pending   (pending)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Youngest queued value for a register, else the register-file value; x0 reads as zero.
    function automatic logic [31:0] opnd(logic [4:0] a, logic [31:0] g);
        if (a == 5'd0) return 32'd0;
        if (!rst)
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].rd == a) return q[i].d;
        return g;
    endfunction

    task automatic drive(bit r, bit v, logic [4:0] rd, logic [31:0] d, bit we,
                         logic [4:0] a, logic [4:0] b, logic [31:0] qa, logic [31:0] qb);
        rst = r; wb_valid = v; wb_rd = rd; wb_data = d; gpr_wr_en = we;
        rs1 = a; rs2 = b; gpr_qa = qa; gpr_qb = qb;
        #1;
    endtask

    task automatic tick();
        bit exp_we, exp_rdy;
        #1;
        exp_rdy = !rst && !rst_prev && q.size() < DEPTH;
        exp_we  = !rst && q.size() > 0 && gpr_wr_en;
        chk("wb_ready", wb_ready, exp_rdy);
        chk("gpr_we", gpr_we, exp_we);
        chk("pending", pending, !rst && q.size() > 0);
        if (exp_we) begin
            chk("gpr_rd", gpr_rd, q[0].rd);
            chk("gpr_di", gpr_di, q[0].d);
        end
        chk("op_a", op_a, opnd(rs1, gpr_qa));
        chk("op_b", op_b, opnd(rs2, gpr_qb));
        @(posedge clk);
        if (rst) begin
            q.delete();
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            if (exp_we) void'(q.pop_front());
            if (wb_valid && exp_rdy && wb_rd != 5'd0) q.push_back('{wb_rd, wb_data});
        end
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_ready", wb_ready, 0);
        chk("rst_pending", pending, 0);
        tick(); tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("post_rst_ready", wb_ready, 0);
        tick();
        // single write
        drive(0, 1, 5, 32'h12345678, 1, 5, 0, 0, 0);
        chk("single_ready", wb_ready, 1);
        tick();
        drive(0, 0, 0, 0, 1, 5, 0, 0, 0);
        chk("single_we", gpr_we, 1);
        chk("single_rd", gpr_rd, 5);
        chk("single_di", gpr_di, 32'h12345678);
        chk("single_op_a", op_a, 32'h12345678);
        tick();
        chk("single_pending", pending, 0);
        tick();
        // fill and stall
        drive(0, 1, 1, 32'hA, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 2, 32'hB, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 3, 32'hC, 0, 0, 0, 0, 0);
        chk("full_ready", wb_ready, 0);
        tick(); tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("drain1_rd", gpr_rd, 1);
        chk("drain1_di", gpr_di, 32'hA);
        tick();
        chk("drain2_rd", gpr_rd, 2);
        chk("drain2_di", gpr_di, 32'hB);
        tick();
        chk("drained", pending, 0);
        // youngest wins
        drive(0, 1, 3, 32'h11, 0, 3, 3, 32'h99, 32'h99); tick();
        drive(0, 1, 3, 32'h22, 0, 3, 3, 32'h99, 32'h99); tick();
        drive(0, 0, 0, 0, 0, 3, 3, 32'h99, 32'h99);
        chk("young_a", op_a, 32'h22);
        chk("young_b", op_b, 32'h22);
        tick();
        drive(0, 0, 0, 0, 1, 3, 3, 32'h99, 32'h99);
        chk("young_head_pop", op_a, 32'h22);
        tick(); tick();
        chk("young_gone", op_a, 32'h99);
        // x0 handling
        drive(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 32'h5, 32'h5);
        chk("x0_ready", wb_ready, 1);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 32'h5, 32'h5);
        chk("x0_we", gpr_we, 0);
        chk("x0_pending", pending, 0);
        chk("x0_op_a", op_a, 0);
        tick();
        // reset mid-drain
        drive(0, 1, 7, 32'h70, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 8, 32'h80, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 1, 7, 0, 32'h55, 0);
        chk("mid_rst_we", gpr_we, 0);
        chk("mid_rst_op_a", op_a, 32'h55);
        tick();
        drive(0, 0, 0, 0, 1, 7, 0, 32'h55, 0);
        chk("after_rst_ready", wb_ready, 0);
        chk("after_rst_pending", pending, 0);
        chk("after_rst_op_a", op_a, 32'h55);
        tick();
        chk("ready_back", wb_ready, 1);
        // simultaneous push/pop
        drive(0, 1, 9, 32'h90, 1, 0, 0, 0, 0); tick();
        drive(0, 1, 10, 32'hA0, 1, 0, 0, 0, 0);
        chk("pp_rd", gpr_rd, 9);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("pp_pending", pending, 1);
        chk("pp_next_rd", gpr_rd, 10);
        chk("pp_next_di", gpr_di, 32'hA0);
        tick();
        chk("pp_empty", pending, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) != 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_wb_ctrl.md
GPR_WB_CTRL -- requirements
Module: gpr_wb_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2: writeback queue depth in entries; a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port wb_valid, input, 1 bit: writeback request valid.
REQ-005 SHALL have port wb_ready, output, 1 bit: writeback request accepted this cycle.
REQ-006 SHALL have port wb_rd, input, 5 bits: destination register.
REQ-007 SHALL have port wb_data, input, 32 bits: writeback value.
REQ-008 SHALL have port gpr_wr_en, input, 1 bit: register-file write slot available this cycle.
REQ-009 SHALL have ports gpr_we (output, 1 bit), gpr_rd (output, 5 bits) and gpr_di (output, 32 bits): register-file write port.
REQ-010 SHALL have ports rs1 and rs2, input, 5 bits each: operand read addresses, also driven to the register file.
REQ-011 SHALL have ports gpr_qa and gpr_qb, input, 32 bits each: register-file read data for rs1 and rs2.
REQ-012 SHALL have ports op_a and op_b, output, 32 bits each: bypassed operands.
REQ-013 SHALL have port pending, output, 1 bit: queue non-empty.

Function
REQ-014 SHALL accept a request on any rising edge where wb_valid=1 and wb_ready=1.
REQ-015 SHALL drive wb_ready = !full && !rst; it SHALL NOT depend combinationally on wb_valid or gpr_wr_en.
REQ-016 SHALL enqueue an accepted request at the tail, except when wb_rd=0: such a request is accepted and then discarded.
REQ-017 SHALL drive gpr_we = !empty && gpr_wr_en, with gpr_rd and gpr_di taken from the head entry; all three SHALL be combinational from queue state.
REQ-018 SHALL pop the head on the edge where gpr_we=1.
REQ-019 SHALL write entries to the register file strictly in acceptance order.
REQ-020 SHALL apply push and pop together on one edge when both occur; the count is then unchanged.
REQ-021 SHALL NOT pass a request through when full: there is no push while full, even if a pop occurs on the same edge.
REQ-022 SHALL wrap head and tail pointers modulo DEPTH, with the count in the range 0..DEPTH.
REQ-023 SHALL drive op_a = 0 when rs1=0; else the data of the youngest queued entry with rd=rs1, if one exists; else gpr_qa.
REQ-024 SHALL compute op_b the same way from rs2 and gpr_qb.
REQ-025 SHALL include the head entry in the bypass search, even in the cycle it is being written.
REQ-026 SHALL NOT bypass from wb_data in the same cycle; an accepted write becomes visible on op_a/op_b from the next cycle.
REQ-027 SHALL drive pending = !empty.
REQ-028 SHALL, with a full queue and gpr_wr_en=0, hold all state and keep wb_ready=0 indefinitely.

Reset
REQ-029 SHALL, on any edge with rst=1, set count, head and tail to 0 and discard all queued entries, including during an active drain.
REQ-030 SHALL hold wb_ready=0, gpr_we=0 and pending=0 while rst=1 and on the first cycle after it.
REQ-031 SHALL, while rst=1, pass op_a/op_b through from gpr_qa/gpr_qb, with zero still forced for address 0.

Structure
REQ-032 SHALL place XLEN=32, REG_ADDR_W=5 and the queue entry typedef {rd, data} in shared package gpr_pkg.
REQ-033 SHALL implement the queue as sub-module wb_fifo, which exposes all entries and their valid bits for the bypass search.
REQ-034 SHALL implement the bypass priority select in gpr_wb_ctrl itself.

Verification
REQ-035 Single write: gpr_wr_en=1; accept rd=5, data=0x12345678 -> next cycle gpr_we=1, gpr_rd=5, gpr_di=0x12345678, op_a=0x12345678 when rs1=5; following cycle pending=0.
REQ-036 Fill and stall: gpr_wr_en=0; accept rd=1 data=0xA, then rd=2 data=0xB -> wb_ready=0 and third request not accepted; raise gpr_wr_en -> writes 1 then 2 in order.
REQ-037 Youngest wins: gpr_wr_en=0; queue rd=3 data=0x11, then rd=3 data=0x22; rs1=rs2=3, gpr_qa=gpr_qb=0x99 -> op_a=op_b=0x22; after both drain, op_a=gpr_qa.
REQ-038 x0 handling: accept rd=0 data=0xFFFFFFFF -> wb_ready=1, no gpr_we ever, pending stays 0; rs1=0 with gpr_qa=0x5 -> op_a=0.
REQ-039 Reset mid-drain: queue two entries with gpr_wr_en=0; assert rst one cycle -> no gpr_we, pending=0, wb_ready=0 for one cycle then 1.
REQ-040 Simultaneous push/pop: count=1, gpr_wr_en=1, wb_valid=1 -> count stays 1 and the new entry is written on the next cycle.
